// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment scan driver: digit count,
// digit index type and the active-low hex segment table (bit 6 = a ... bit 0 = g).
`timescale 1ns/1ps
package seg7_pkg;

    localparam int NUM_DIGITS = 4;

    typedef logic [1:0] digit_idx_t;

    // Entry n is the a..g pattern for hex digit n, written MSB = a; 0 lights a segment.
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'b0000001,  // 0
        7'b1001111,  // 1
        7'b0010010,  // 2
        7'b0000110,  // 3
        7'b1001100,  // 4
        7'b0100100,  // 5
        7'b0100000,  // 6
        7'b0001111,  // 7
        7'b0000000,  // 8
        7'b0000100,  // 9
        7'b0001000,  // A
        7'b1100000,  // b
        7'b0110001,  // C
        7'b1000010,  // d
        7'b0110000,  // E
        7'b0111000   // F
    };

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational 4-bit to seven-segment decode; seg[0] is segment a, active-low.
`timescale 1ns/1ps
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [0:6] seg
);

    // Table MSB lands on seg[0] (segment a).
    assign seg = SEG_TABLE[nibble];

endmodule

// File: rtl/seg7_scan_driver.sv
// Four-digit multiplexed common-anode display driver. Shows the low 16 bits of
// the counter value as hex, snapshotted once per frame, with a dark guard window
// at the start of every digit slot to suppress ghosting. Outputs are registered.
`timescale 1ns/1ps
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter int GUARD       = 16
) (
    input  logic        clk,
    input  logic        i_reset,
    input  logic [0:31] i_count,
    input  logic        i_en,
    input  logic        i_blank_lz,
    input  logic [0:3]  i_dp_mask,
    output logic [0:6]  seg,
    output logic [0:3]  an,
    output logic        dp
);

    localparam int PW     = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam int SNAP_W = 4 * NUM_DIGITS;
    localparam logic [PW-1:0] P_LAST  = PW'(REFRESH_DIV - 1);
    localparam logic [PW-1:0] GUARD_P = PW'(GUARD);

    logic [PW-1:0]     p_reg, p_next;
    digit_idx_t        d_reg, d_next;
    logic [SNAP_W-1:0] snap_reg, snap_next;
    logic [0:6]        seg_reg, seg_next;
    logic [0:3]        an_reg, an_next;
    logic              dp_reg, dp_next;

    logic                  slot_end;
    logic                  lit;
    logic [3:0]            cur_nibble;
    logic [0:6]            cur_seg;
    logic [NUM_DIGITS-1:0] digit_blank;

    // Only the low 16 bits of the count are displayed; i_count[31] is the LSB.
    logic unused_count_hi;
    assign unused_count_hi = ^i_count[0:15];

    assign slot_end   = (p_reg == P_LAST);
    assign cur_nibble = snap_reg[{d_reg, 2'b00} +: 4];

    // Digit 0 always shows; higher digits blank while they and all above are zero.
    assign digit_blank[0] = 1'b0;
    genvar gi;
    generate
        for (gi = 1; gi < NUM_DIGITS; gi++) begin : g_blank
            assign digit_blank[gi] = i_blank_lz && (snap_reg[SNAP_W-1:4*gi] == '0);
        end
    endgenerate

    seg7_hex_decode u_hex_decode (
        .nibble (cur_nibble),
        .seg    (cur_seg)
    );

    assign lit = (p_reg >= GUARD_P) && i_en && !digit_blank[d_reg];

    // Next-state scan position, frame snapshot and output pattern.
    always_comb begin
        p_next    = slot_end ? '0 : p_reg + 1'b1;
        d_next    = slot_end ? d_reg + 2'd1 : d_reg;
        snap_next = (slot_end && (d_reg == 2'd3)) ? i_count[16:31] : snap_reg;
        an_next   = '1;
        seg_next  = '1;
        dp_next   = 1'b1;
        if (lit) begin
            an_next[d_reg] = 1'b0;
            seg_next       = cur_seg;
            dp_next        = ~i_dp_mask[d_reg];
        end
    end

    // State and output registers; active-low synchronous reset blanks the display.
    always_ff @(posedge clk) begin
        if (!i_reset) begin
            p_reg    <= '0;
            d_reg    <= '0;
            snap_reg <= '0;
            an_reg   <= '1;
            seg_reg  <= '1;
            dp_reg   <= 1'b1;
        end else begin
            p_reg    <= p_next;
            d_reg    <= d_next;
            snap_reg <= snap_next;
            an_reg   <= an_next;
            seg_reg  <= seg_next;
            dp_reg   <= dp_next;
        end
    end

    assign seg = seg_reg;
    assign an  = an_reg;
    assign dp  = dp_reg;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver with REFRESH_DIV=4, GUARD=1.
// A cycle-level reference predicts each registered output; predictions are
// queued before the clock edge and compared just after it.
`timescale 1ns/1ps
module tb_seg7_scan_driver;

    localparam int DIV = 4;
    localparam int GRD = 1;

    logic        clk;
    logic        i_reset;
    logic [0:31] i_count;
    logic        i_en;
    logic        i_blank_lz;
    logic [0:3]  i_dp_mask;
    logic [0:6]  seg;
    logic [0:3]  an;
    logic        dp;

    typedef struct {
        logic [0:3] an;
        logic [0:6] seg;
        logic       dp;
    } exp_t;

    exp_t sb_q[$];

    int vectors    = 0;
    int miscompares = 0;

    // Reference state: cycles since reset release and the displayed value.
    int          m_cyc  = 0;
    logic [15:0] m_snap = '0;
    logic [31:0] cnt_val = '0;

    seg7_scan_driver #(
        .REFRESH_DIV (DIV),
        .GUARD       (GRD)
    ) dut (
        .clk        (clk),
        .i_reset    (i_reset),
        .i_count    (i_count),
        .i_en       (i_en),
        .i_blank_lz (i_blank_lz),
        .i_dp_mask  (i_dp_mask),
        .seg        (seg),
        .an         (an),
        .dp         (dp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [0:6] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'b0000001;
            4'h1: hex7 = 7'b1001111;
            4'h2: hex7 = 7'b0010010;
            4'h3: hex7 = 7'b0000110;
            4'h4: hex7 = 7'b1001100;
            4'h5: hex7 = 7'b0100100;
            4'h6: hex7 = 7'b0100000;
            4'h7: hex7 = 7'b0001111;
            4'h8: hex7 = 7'b0000000;
            4'h9: hex7 = 7'b0000100;
            4'hA: hex7 = 7'b0001000;
            4'hB: hex7 = 7'b1100000;
            4'hC: hex7 = 7'b0110001;
            4'hD: hex7 = 7'b1000010;
            4'hE: hex7 = 7'b0110000;
            default: hex7 = 7'b0111000;
        endcase
    endfunction

    // Index of the most significant nonzero nibble (0 when the value is zero).
    function automatic int top_digit(input logic [15:0] v);
        int t;
        t = 0;
        for (int k = 0; k < 4; k++)
            if (((v >> (4 * k)) & 16'hF) != 16'h0) t = k;
        return t;
    endfunction

    task automatic tick();
        exp_t e;
        exp_t got;
        int   p;
        int   d;
        logic on;
        e.an  = 4'b1111;
        e.seg = 7'b1111111;
        e.dp  = 1'b1;
        p = m_cyc % DIV;
        d = (m_cyc / DIV) % 4;
        if (i_reset) begin
            on = (p >= GRD) && i_en && !(i_blank_lz && d > top_digit(m_snap));
            if (on) begin
                e.an[d] = 1'b0;
                e.seg   = hex7(4'((m_snap >> (4 * d)) & 16'hF));
                e.dp    = ~i_dp_mask[d];
            end
        end
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        if (!i_reset) begin
            m_cyc  = 0;
            m_snap = '0;
        end else begin
            if (p == DIV - 1 && d == 3) m_snap = cnt_val[15:0];
            m_cyc++;
        end
        got = sb_q.pop_front();
        vectors++;
        $display("vec %0d cnt=%h an=%b seg=%b dp=%b", vectors, cnt_val[15:0], an, seg, dp);
        assert (an === got.an) else begin
            miscompares++;
            $error("FAIL an vec %0d: observed %b expected %b", vectors, an, got.an);
        end
        assert (seg === got.seg) else begin
            miscompares++;
            $error("FAIL seg vec %0d: observed %b expected %b", vectors, seg, got.seg);
        end
        assert (dp === got.dp) else begin
            miscompares++;
            $error("FAIL dp vec %0d: observed %b expected %b", vectors, dp, got.dp);
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic set_count(input logic [31:0] v);
        cnt_val = v;
        i_count = v;
    endtask

    initial begin
        i_reset    = 1'b0;
        i_en       = 1'b1;
        i_blank_lz = 1'b1;
        i_dp_mask  = 4'b0000;
        set_count(32'h0);

        // Reset held, then first frame showing a lone "0".
        run(3);
        i_reset = 1'b1;
        run(16);

        // 0x1A8F without blanking; loaded at the end of this frame, shown next.
        set_count(32'hDEAD_1A8F);
        i_blank_lz = 1'b0;
        run(32);

        // Decimal points on digits 1 and 3, then display disable and re-enable.
        i_dp_mask = 4'b0101;
        run(16);
        i_en = 1'b0;
        run(6);
        i_en = 1'b1;
        run(10);
        i_dp_mask = 4'b0000;

        // 0x0012 with leading-zero blanking.
        set_count(32'h0000_0012);
        i_blank_lz = 1'b1;
        run(32);

        // Mid-frame change: 0x1111 held, then 0x2222 during digit 1's slot.
        set_count(32'h0000_1111);
        run(16);
        run(6);
        set_count(32'h0000_2222);
        run(26);

        // One-cycle reset during digit 2's lit window.
        run(9);
        i_reset = 1'b0;
        run(1);
        i_reset = 1'b1;
        run(20);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
